// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding and the default oversampling
// ratio used by the transmitter, receiver and baud generator.
package uart_tx_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// stop bit(s), all paced by the shared OVERSAMPLE-per-bit baud_tick strobe.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int STOP_TICKS = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int CW       = $clog2(TICK_MAX);
  localparam int NW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_e               state_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [NW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic [CW-1:0]        tick_limit;
  logic                 bit_end;

  // The stop bit may be longer than a data bit, so its limit differs.
  always_comb begin
    tick_limit = (state_q == STOP) ? CW'(STOP_TICKS - 1) : CW'(OVERSAMPLE - 1);
    bit_end    = baud_tick && (state_q != IDLE) && (tick_cnt_q == tick_limit);
  end

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // blocking assignments would let later statements observe updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && baud_tick) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            shift_q    <= tx_data;
            parity_q   <= (^tx_data) ^ PARITY_ODD;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + NW'(1);
            if (bit_cnt_q == NW'(DATA_BITS - 1)) begin
              if (PARITY_EN) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              // Present the next bit now so tx stays a pure register output.
              tx_q <= shift_q[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (no parity, even, odd) share
// clock, reset and a baud_tick every 4 clk; a monitor per instance decodes tx.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       tx_start_w [3];
  logic [7:0] tx_data_w  [3];
  logic       tx_w       [3];
  logic       busy_w     [3];
  logic       done_w     [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data_q [3][$];
  logic       exp_par_q  [3][$];
  int         exp_done   [3];
  int         done_cnt   [3];

  uart_tx dut0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0])
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1])
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start_w[2]), .tx_data(tx_data_w[2]),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int c;
    c = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      baud_tick = (c % 4 == 0);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_frame(input int idx, input logic [7:0] d, input logic p);
    exp_data_q[idx].push_back(d);
    exp_par_q[idx].push_back(p);
    exp_done[idx]++;
  endtask

  task automatic wait_n(input int n, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        aborted = 1'b1;
        break;
      end
    end
  endtask

  // Samples each bit near its centre, 64 clk apart, starting 32 clk after tx falls.
  task automatic monitor(input int idx);
    bit         ab;
    bit         done_seen;
    logic [7:0] got;
    logic       gp;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx_w[idx] === 1'b0) begin
        got = '0;
        gp  = 1'b0;
        wait_n(31, ab);
        if (!ab) check($sformatf("start_bit[%0d]", idx), tx_w[idx], 1'b0);
        for (int b = 0; b < 8 && !ab; b++) begin
          wait_n(64, ab);
          if (!ab) got[b] = tx_w[idx];
        end
        if (idx != 0 && !ab) begin
          wait_n(64, ab);
          gp = tx_w[idx];
        end
        if (!ab) begin
          wait_n(64, ab);
          if (!ab) check($sformatf("stop_bit[%0d]", idx), tx_w[idx], 1'b1);
        end
        if (!ab) begin
          done_seen = 1'b0;
          for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (reset !== 1'b1) begin
              ab = 1'b1;
              break;
            end
            if (done_w[idx] === 1'b1) begin
              done_seen = 1'b1;
              break;
            end
          end
          if (!ab) check($sformatf("done_after_stop[%0d]", idx), done_seen, 1'b1);
        end
        if (ab) begin
          wait (reset === 1'b1);
        end else begin
          check($sformatf("frame_expected[%0d]", idx), exp_data_q[idx].size() != 0, 1'b1);
          if (exp_data_q[idx].size() != 0) begin
            logic [7:0] ed;
            logic       ep;
            ed = exp_data_q[idx].pop_front();
            ep = exp_par_q[idx].pop_front();
            check($sformatf("data[%0d]", idx), got, ed);
            if (idx != 0) check($sformatf("parity[%0d]", idx), gp, ep);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join
  end

  // Raise tx_start so it is accepted on a baud_tick edge; the start bit then
  // lasts exactly 64 clk from the edge where tx falls.
  task automatic send(input int idx, input logic [7:0] d);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (baud_tick !== 1'b1 && k < 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tx_data_w[idx]  = d;
    tx_start_w[idx] = 1'b1;
    @(negedge clk);
    tx_start_w[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy_w[idx] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("idle_within_budget[%0d]", idx), ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int         len;
    int         done_before;
    bit         ok;
    int         v_idx [4];
    logic [7:0] v_dat [4];
    logic       v_par [4];

    // Hand-computed parity: 0x07 has three ones, 0x03 has two.
    v_idx[0] = 1; v_dat[0] = 8'h07; v_par[0] = 1'b1;
    v_idx[1] = 1; v_dat[1] = 8'h03; v_par[1] = 1'b0;
    v_idx[2] = 2; v_dat[2] = 8'h07; v_par[2] = 1'b0;
    v_idx[3] = 2; v_dat[3] = 8'h03; v_par[3] = 1'b1;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_start_w[i] = 1'b0;
      tx_data_w[i]  = 8'h00;
      exp_done[i]   = 0;
    end

    repeat (3) begin
      @(negedge clk);
      check("reset_tx", tx_w[0], 1'b1);
      check("reset_busy", busy_w[0], 1'b0);
      check("reset_done", done_w[0], 1'b0);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_tx", tx_w[0], 1'b1);
      check("idle_busy", busy_w[0], 1'b0);
    end

    // 0x55, defaults; the start bit length also shows the acceptance tick is not counted.
    expect_frame(0, 8'h55, 1'b0);
    send(0, 8'h55);
    check("busy_after_accept", busy_w[0], 1'b1);
    len = 0;
    while (tx_w[0] === 1'b0 && len < 100) begin
      len++;
      @(negedge clk);
    end
    check("start_len_clk", len, 64);
    wait_idle(0);

    for (int v = 0; v < 4; v++) begin
      expect_frame(v_idx[v], v_dat[v], v_par[v]);
      send(v_idx[v], v_dat[v]);
      wait_idle(v_idx[v]);
    end

    // A request while busy is dropped.
    repeat (40) @(negedge clk);
    done_before = done_cnt[0];
    expect_frame(0, 8'hA5, 1'b0);
    send(0, 8'hA5);
    repeat (200) @(negedge clk);
    tx_data_w[0]  = 8'hFF;
    tx_start_w[0] = 1'b1;
    @(negedge clk);
    tx_start_w[0] = 1'b0;
    wait_idle(0);
    repeat (40) @(negedge clk);
    check("ignored_start_no_frame", busy_w[0], 1'b0);
    check("midframe_done_count", done_cnt[0] - done_before, 1);

    // tx_start held high: two frames separated by one idle clk.
    expect_frame(0, 8'h00, 1'b0);
    expect_frame(0, 8'hFF, 1'b0);
    tx_data_w[0]  = 8'h00;
    tx_start_w[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy_w[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_accept", ok, 1'b1);
    tx_data_w[0] = 8'hFF;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_done", ok, 1'b1);
    check("b2b_idle_high", tx_w[0], 1'b1);
    check("b2b_busy_drop", busy_w[0], 1'b0);
    @(negedge clk);
    check("b2b_gap_one_clk", tx_w[0], 1'b0);
    check("b2b_second_busy", busy_w[0], 1'b1);
    tx_start_w[0] = 1'b0;
    wait_idle(0);

    // Reset during data bit 3 (0xA3 has bit 3 = 0, so tx is low beforehand).
    repeat (40) @(negedge clk);
    done_before = done_cnt[0];
    send(0, 8'hA3);
    repeat (288) @(negedge clk);
    check("pre_abort_tx_low", tx_w[0], 1'b0);
    #1 reset = 1'b0;
    #1;
    check("abort_tx_async", tx_w[0], 1'b1);
    check("abort_busy_async", busy_w[0], 1'b0);
    check("abort_done_async", done_w[0], 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_done_held", done_w[0], 1'b0);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt[0] - done_before, 0);
    expect_frame(0, 8'h5A, 1'b0);
    send(0, 8'h5A);
    wait_idle(0);

    repeat (60) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("queue_drained[%0d]", i), exp_data_q[i].size(), 0);
      check($sformatf("done_count[%0d]", i), done_cnt[i], exp_done[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
